// File: rtl/adder_pkg.sv
// Shared constants for the multi-word add/sub sequencer: FSM encoding and
// default datapath geometry.
package adder_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_WORDS = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain WIDTH-bit ripple-carry adder; the only arithmetic in the sequencer.
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  // NOTE: every output of a combinational block gets a default before any
  // conditional/loop assignment, otherwise synthesis infers a latch.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Streams multi-word operands (LS word first) through one narrow adder, carrying
// between words in a register; 1-deep output register with pass-through backpressure.
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  logic [0:0]       state_q, state_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             first_word;
  logic             sub_eff;
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CW-1:0]    cnt_inc;
  logic             end_frame;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_word = (state_q == ST_IDLE);
  assign sub_eff    = first_word ? in_sub : sub_q;
  assign cin        = first_word ? in_sub : carry_q;
  assign b_eff      = sub_eff ? ~in_b : in_b;
  // Count including the word being accepted; a first word always counts as 1.
  assign cnt_inc    = (first_word ? CW'(0) : cnt_q) + CW'(1);
  assign end_frame  = in_last || (cnt_inc == CW'(MAX_WORDS));

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum;
      out_cout_d  = cout;
      cnt_d       = cnt_inc;
      if (first_word) sub_d = in_sub;
      if (end_frame) begin
        out_last_d = 1'b1;
        out_err_d  = !in_last;
        state_d    = ST_IDLE;
        carry_d    = 1'b0;
      end else begin
        out_last_d = 1'b0;
        out_err_d  = 1'b0;
        state_d    = ST_RUN;
        carry_d    = cout;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: directed vector table, hand-written stall/reset sequences,
// and random frames checked against a wide-integer model.
module tb_multiword_add_sequencer;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_last;
  logic             out_cout;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  multiword_add_sequencer #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       last;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_last;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       last;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic last);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_last  = last;
  endtask

  task automatic check_out(input string tag, input logic [7:0] s, input logic c,
                           input logic l, input logic e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(s));
    check({tag, "_cout"},  32'(out_cout),  32'(c));
    check({tag, "_last"},  32'(out_last),  32'(l));
    check({tag, "_err"},   32'(out_err),   32'(e));
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic last, input logic [7:0] s, input logic c,
                         input logic l, input logic e);
    vec_t v;
    v = '{a, b, sub, last, s, c, l, e};
    vecs.push_back(v);
  endtask

  // Wide-integer reference: the whole frame is one n*8-bit add/sub; word i's
  // carry out is bit 8*(i+1) of the partial sum over the low i+1 words.
  task automatic gen_frame(input int n, input logic sub, input logic [31:0] a,
                           input logic [31:0] b);
    longint unsigned mask, beff, partial;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      mask    = (64'd1 << (8 * (i + 1))) - 64'd1;
      beff    = sub ? {32'd0, ~b} : {32'd0, b};
      partial = ({32'd0, a} & mask) + (beff & mask) + {63'd0, sub};
      e.sum   = 8'(partial >> (8 * i));
      e.cout  = partial[8 * (i + 1)];
      e.last  = (i == n - 1);
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  int          fr_left, fr_n, fr_wi;
  logic        fr_sub, prev_acc, in_acc, out_acc;
  logic [31:0] fr_a, fr_b;
  exp_t        ex;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum),   32'd0);
    check("rst_flags", {29'd0, out_last, out_cout, out_err}, 32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // 0x12FF + 0x0001
    add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec(8'h12, 8'h00, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
    // 0x0005 - 0x0007 (borrow out)
    add_vec(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    // Over-long frame: truncated at word 4, word 5 starts a new sub frame
    add_vec(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec(8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    add_vec(8'h7F, 8'h80, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    add_vec(8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    add_vec(8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    // Single-word subtract frame
    add_vec(8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
    // Exactly MAX_WORDS words with in_last on the final one: no error
    add_vec(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    add_vec(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0)
        check_out($sformatf("vec%0d", i - 1), vecs[i-1].e_sum, vecs[i-1].e_cout,
                  vecs[i-1].e_last, vecs[i-1].e_err);
      if (i < vecs.size())
        drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].last);
      else
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end

    // Output stall with a word pending, then release for back-to-back words
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d_sum", i),   32'(out_sum),  32'h33);
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_out("b2b0", 8'h03, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h0A, 8'h05, 1'b0, 1'b1);
    @(negedge clk);
    check_out("b2b1", 8'h0F, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Async reset between word 1 and word 2 of a frame
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check_out("prerst", 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",   32'(out_sum),   32'd0);
    check("midrst_cout",  32'(out_cout),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    check_out("postrst", 8'h02, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);

    // Random frames with stalls on both sides against the wide-integer model
    fr_left  = 40;
    fr_wi    = 0;
    fr_n     = 0;
    prev_acc = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_acc) begin
        fr_wi++;
        in_valid = 1'b0;
      end
      if (fr_wi >= fr_n && fr_left > 0 && !in_valid) begin
        fr_n  = $urandom_range(1, MAX_WORDS);
        fr_sub = 1'($urandom_range(0, 1));
        fr_a  = $urandom;
        fr_b  = $urandom;
        fr_wi = 0;
        fr_left--;
        gen_frame(fr_n, fr_sub, fr_a, fr_b);
      end
      if (!in_valid && fr_wi < fr_n && $urandom_range(0, 3) != 0)
        drive(1'b1, fr_a[8*fr_wi +: 8], fr_b[8*fr_wi +: 8],
              (fr_wi == 0) ? fr_sub : 1'($urandom_range(0, 1)), (fr_wi == fr_n - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      in_acc  = in_valid && in_ready;
      out_acc = out_valid && out_ready;
      if (out_acc) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          ex = exp_q.pop_front();
          check("rnd_sum",  32'(out_sum),  32'(ex.sum));
          check("rnd_cout", 32'(out_cout), 32'(ex.cout));
          check("rnd_last", 32'(out_last), 32'(ex.last));
          check("rnd_err",  32'(out_err),  32'(ex.err));
        end
      end
      prev_acc = in_acc;
      if (fr_left == 0 && fr_wi >= fr_n && !in_valid && exp_q.size() == 0 && !out_valid)
        break;
      @(negedge clk);
    end
    check("rnd_frames_left", 32'(fr_left), 32'd0);
    check("rnd_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
